// File: rtl/param_computer_pkg.sv
// Shared encodings for the parametrised two-register computer: ALU/jump codes,
// FSM states and instruction field offsets expressed as functions of LIT_W.
package computer_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JMP  = 2'b01,
    JMP_JEQ  = 2'b10,
    JMP_HALT = 2'b11
  } jmp_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam int ALU_S_W = 2;
  localparam int JMP_W   = 2;

  // Field layout: lit | alu_s(2) | loadA | loadB | selB | jmp(2), LSB first.
  function automatic int alu_s_lo(input int lit_w);
    return lit_w;
  endfunction

  function automatic int load_a_bit(input int lit_w);
    return lit_w + 2;
  endfunction

  function automatic int load_b_bit(input int lit_w);
    return lit_w + 3;
  endfunction

  function automatic int sel_b_bit(input int lit_w);
    return lit_w + 4;
  endfunction

  function automatic int jmp_lo(input int lit_w);
    return lit_w + 5;
  endfunction

endpackage

// File: rtl/param_computer_if.sv
// Instruction-memory write port of param_computer.
// Handshake: single-beat strobe with no ready; the slave stores wdata at waddr on
// every rising clock edge where we=1, regardless of the core's run/stall state.
interface param_computer_if #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 11
);
  logic               we;
  logic [PC_W-1:0]    waddr;
  logic [INSTR_W-1:0] wdata;

  modport master (output we, waddr, wdata);
  modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/param_computer_alu.sv
// Combinational DATA_W-bit ALU: ADD (carry-out), SUB (borrow = a<b), AND, OR.
module alu_param
  import computer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           s,
  output logic [DATA_W-1:0] out,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    out   = '0;
    carry = 1'b0;
    unique case (s)
      ALU_ADD: begin
        out   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      ALU_SUB: begin
        out   = a - b;
        carry = (a < b);
      end
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
    endcase
  end

endmodule

// File: rtl/param_computer.sv
// Two-register teaching computer: writable IM, A/B registers, Z/C flags,
// JMP/JEQ/HALT sequencing and a global enable that stalls all core state.
module param_computer
  import computer_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int PC_W    = 4,
  parameter  int LIT_W   = 4,
  localparam int INSTR_W = LIT_W + 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  param_computer_if.slave     im,
  output logic [PC_W-1:0]     pc_out,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [DATA_W-1:0]   alu_out,
  output logic [DATA_W-1:0]   regA_out,
  output logic [DATA_W-1:0]   regB_out,
  output logic                flag_z,
  output logic                flag_c,
  output logic                halted,
  output state_t              state_dbg
);

  localparam int ALU_LO = alu_s_lo(LIT_W);
  localparam int LA_BIT = load_a_bit(LIT_W);
  localparam int LB_BIT = load_b_bit(LIT_W);
  localparam int SB_BIT = sel_b_bit(LIT_W);
  localparam int JMP_LO = jmp_lo(LIT_W);

  logic [INSTR_W-1:0] imem [2**PC_W];

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              z_q, z_d, c_q, c_d;
  state_t            state_q, state_d;

  logic [INSTR_W-1:0] instr;
  logic [LIT_W-1:0]   lit;
  logic [PC_W-1:0]    lit_pc, pc_inc;
  alu_op_t            alu_s;
  jmp_t               jmp;
  logic               load_a, load_b, sel_b;
  logic [DATA_W-1:0]  b_mux, alu_res;
  logic               alu_c;

  // IM is deliberately not reset; a write to the current PC is seen next cycle.
  always_ff @(posedge clk) begin
    if (im.we) imem[im.waddr] <= im.wdata;
  end

  assign instr  = imem[pc_q];
  assign lit    = instr[LIT_W-1:0];
  assign lit_pc = lit[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign alu_s  = alu_op_t'(instr[ALU_LO +: ALU_S_W]);
  assign jmp    = jmp_t'(instr[JMP_LO +: JMP_W]);
  assign load_a = instr[LA_BIT];
  assign load_b = instr[LB_BIT];
  assign sel_b  = instr[SB_BIT];
  assign b_mux  = sel_b ? DATA_W'(lit) : b_q;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (b_mux),
    .s     (alu_s),
    .out   (alu_res),
    .carry (alu_c)
  );

  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    c_d     = c_q;
    state_d = state_q;
    if (en && (state_q == ST_RUN)) begin
      if (load_a) a_d = alu_res;
      if (load_b) b_d = alu_res;
      if (load_a || load_b) begin
        z_d = (alu_res == '0);
        c_d = alu_c;
      end
      // JEQ tests the flag as it stood before this instruction's own update.
      unique case (jmp)
        JMP_NONE: pc_d = pc_inc;
        JMP_JMP:  pc_d = lit_pc;
        JMP_JEQ:  pc_d = z_q ? lit_pc : pc_inc;
        JMP_HALT: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      c_q     <= c_d;
      state_q <= state_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr;
  assign alu_out   = alu_res;
  assign regA_out  = a_q;
  assign regB_out  = b_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_param_computer.sv
// Bench for param_computer: directed programs plus random programs/enables/IM writes,
// checked against an instruction-level model of the computer kept in plain integers.
module tb_param_computer;
  import computer_pkg::*;

  localparam int DATA_W  = 8;
  localparam int PC_W    = 4;
  localparam int LIT_W   = 4;
  localparam int INSTR_W = 11;
  localparam int DEPTH   = 16;
  localparam int W       = 23;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [DATA_W-1:0]  alu_out, regA_out, regB_out;
  logic               flag_z, flag_c, halted;
  state_t             state_dbg;

  param_computer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) im_bus ();

  param_computer #(.DATA_W(DATA_W), .PC_W(PC_W), .LIT_W(LIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .im        (im_bus),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .alu_out   (alu_out),
    .regA_out  (regA_out),
    .regB_out  (regB_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int m_pc, m_a, m_b, m_z, m_c, m_halt;
  int m_mem [DEPTH];
  int prog  [DEPTH];
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int enc(input int jmp, input int selb, input int lb, input int la,
                             input int op, input int lit);
    return jmp * 512 + selb * 256 + lb * 128 + la * 64 + op * 16 + lit;
  endfunction

  function automatic int rand_instr();
    int js, jmp;
    js  = $urandom_range(0, 99);
    jmp = (js < 70) ? 0 : (js < 85) ? 1 : (js < 97) ? 2 : 3;
    return enc(jmp, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 15));
  endfunction

  // Result and carry of the word at m_pc, from the arithmetic meaning of each op.
  task automatic model_alu(output int r, output int c);
    int instr, lit, op, bv;
    instr = m_mem[m_pc];
    r = 0;
    c = 0;
    if (instr >= 0) begin
      lit = instr % 16;
      op  = (instr / 16) % 4;
      bv  = ((instr / 256) % 2 == 1) ? lit : m_b;
      case (op)
        0: begin r = m_a + bv; c = (r > 255) ? 1 : 0; r = r % 256; end
        1: begin c = (m_a < bv) ? 1 : 0; r = (m_a - bv + 256) % 256; end
        2: r = m_a & bv;
        default: r = m_a | bv;
      endcase
    end
  endtask

  task automatic model_exec(input bit en_v);
    int instr, r, c, la, lb, jmp, lit, z_old;
    if (!en_v || m_halt == 1) return;
    model_alu(r, c);
    instr = m_mem[m_pc];
    lit   = instr % 16;
    la    = (instr / 64) % 2;
    lb    = (instr / 128) % 2;
    jmp   = (instr / 512) % 4;
    z_old = m_z;
    if (la == 1) m_a = r;
    if (lb == 1) m_b = r;
    if (la == 1 || lb == 1) begin
      m_z = (r == 0) ? 1 : 0;
      m_c = c;
    end
    case (jmp)
      0: m_pc = (m_pc + 1) % DEPTH;
      1: m_pc = lit % DEPTH;
      2: m_pc = (z_old == 1) ? lit % DEPTH : (m_pc + 1) % DEPTH;
      default: m_halt = 1;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive en / IM write, predict, then score the registered state.
  task automatic step(input bit en_v, input bit we_v, input int wa, input int wd);
    int r, c;
    logic [W-1:0] e;
    @(negedge clk);
    en           = en_v;
    im_bus.we    = we_v;
    im_bus.waddr = wa[PC_W-1:0];
    im_bus.wdata = wd[INSTR_W-1:0];
    #1;
    if (m_mem[m_pc] >= 0) begin
      model_alu(r, c);
      check("instr_out", instr_out, m_mem[m_pc]);
      check("alu_out", alu_out, r);
    end
    model_exec(en_v);
    if (we_v) m_mem[wa] = wd;
    exp_q.push_back({m_halt[0], m_c[0], m_z[0], m_pc[3:0], m_b[7:0], m_a[7:0]});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc_out", pc_out, e[19:16]);
    check("regA_out", regA_out, e[7:0]);
    check("regB_out", regB_out, e[15:8]);
    check("flag_z", flag_z, e[20]);
    check("flag_c", flag_c, e[21]);
    check("halted", halted, e[22]);
    check("state_dbg", state_dbg, e[22]);
    en        = 1'b0;
    im_bus.we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, prog[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) prog[i] = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, pc_out, 0);
    check({tag, "_regA"}, regA_out, 0);
    check({tag, "_regB"}, regB_out, 0);
    check({tag, "_z"}, flag_z, 0);
    check({tag, "_c"}, flag_c, 0);
    check({tag, "_halted"}, halted, 0);
  endtask

  // Asynchronous pulse in the middle of the low phase; values must clear before any edge.
  task automatic pulse_rst(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int exp_a1 [5] = '{3, 4, 5, 6, 6};
  int body_cnt;

  initial begin
    rst = 1'b1; en = 1'b0;
    im_bus.we = 1'b0; im_bus.waddr = '0; im_bus.wdata = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // 1: accumulate into A, then HALT and stay frozen
    clear_prog();
    prog[0] = enc(0, 1, 0, 1, 0, 3);
    for (int i = 1; i < 4; i++) prog[i] = enc(0, 1, 0, 1, 0, 1);
    prog[4] = enc(3, 0, 0, 0, 0, 0);
    load_prog();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 0, 0);
      check("t1_regA", regA_out, exp_a1[i]);
    end
    run(10);
    check("t1_halted", halted, 1);
    check("t1_pc", pc_out, 4);
    check("t1_regA_hold", regA_out, 6);

    // 6: reset while halted and while running, program re-executes
    pulse_rst("rst_halted");
    run(2);
    pulse_rst("rst_running");
    run(6);
    check("t6_regA", regA_out, 6);

    // 2: SUB borrow, OR, ADD wrap to zero
    pulse_rst("t2_rst");
    clear_prog();
    prog[0] = enc(0, 1, 0, 1, 0, 2);
    prog[1] = enc(0, 1, 0, 1, 1, 5);
    prog[2] = enc(0, 1, 0, 1, 3, 2);
    prog[3] = enc(0, 1, 0, 1, 0, 1);
    prog[4] = enc(3, 0, 0, 0, 0, 0);
    load_prog();
    run(2);
    check("t2_sub_a", regA_out, 8'hFD);
    check("t2_sub_c", flag_c, 1);
    check("t2_sub_z", flag_z, 0);
    run(2);
    check("t2_add_a", regA_out, 0);
    check("t2_add_z", flag_z, 1);
    check("t2_add_c", flag_c, 1);

    // 3: countdown loop with JEQ exit
    pulse_rst("t3_rst");
    clear_prog();
    prog[0] = enc(0, 1, 0, 1, 0, 3);
    prog[1] = enc(0, 1, 0, 1, 1, 1);
    prog[2] = enc(2, 0, 0, 0, 0, 4);
    prog[3] = enc(1, 0, 0, 0, 0, 1);
    prog[4] = enc(3, 0, 0, 0, 0, 0);
    load_prog();
    body_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 0, 0);
      if (pc_out == 4'd1) body_cnt++;
    end
    check("t3_body_count", body_cnt, 3);
    check("t3_halted", halted, 1);
    check("t3_pc", pc_out, 4);
    check("t3_regA", regA_out, 0);

    // 4: PC wrap, same-cycle IM write at PC, JMP
    pulse_rst("t4_rst");
    clear_prog();
    load_prog();
    run(15);
    check("t4_pc15", pc_out, 15);
    run(1);
    check("t4_wrap", pc_out, 0);
    step(1'b1, 1'b1, 0, enc(1, 0, 0, 0, 0, 7));
    check("t4_old_word", pc_out, 1);
    step(1'b1, 1'b1, 2, enc(1, 0, 0, 0, 0, 7));
    run(1);
    check("t4_jmp7", pc_out, 7);

    // 5: stall for five cycles mid-program
    pulse_rst("t5_rst");
    clear_prog();
    prog[0] = enc(0, 1, 0, 1, 0, 3);
    prog[1] = enc(0, 1, 1, 0, 0, 2);
    prog[2] = enc(0, 0, 0, 1, 0, 0);
    prog[3] = enc(0, 0, 0, 1, 1, 0);
    prog[4] = enc(1, 0, 0, 0, 0, 1);
    load_prog();
    run(3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 0, 0);
      check("t5_pc", pc_out, 3);
      check("t5_regA", regA_out, 8);
      check("t5_regB", regB_out, 5);
    end
    run(3);
    check("t5_resume_a", regA_out, 3);

    // random programs, enables, IM writes and resets
    pulse_rst("rand_rst");
    for (int i = 0; i < DEPTH; i++) prog[i] = rand_instr();
    load_prog();
    for (int i = 0; i < 500; i++) begin
      if ((m_halt == 1 && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
        pulse_rst("rand_rst");
      step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
           $urandom_range(0, DEPTH - 1), rand_instr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
